// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel
// Description : Multi-channel PWM with clock prescaler, runtime period/duty
//               and shadowed updates that only take effect at period ends.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter int NUM_CH       = 4,
    parameter int DUTY_W       = 8,
    parameter int PRESCALE     = 50,
    parameter int RESET_PERIOD = 255
) (
    input  logic                     clk_50MHz,
    input  logic                     reset,
    input  logic [DUTY_W-1:0]        period,
    input  logic [NUM_CH*DUTY_W-1:0] duty,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     load,
    output logic                     pending,
    output logic                     update_done,
    output logic                     tick,
    output logic                     clk_div,
    output logic                     period_end,
    output logic                     frame_clk,
    output logic [NUM_CH-1:0]        pwm_out
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  c_pre_max      = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]  c_pre_half     = PRE_W'(PRESCALE / 2);
    localparam logic [DUTY_W-1:0] c_reset_period = DUTY_W'(RESET_PERIOD);

    logic [PRE_W-1:0]         r_pre_cnt;
    logic [PRE_W-1:0]         w_pre_next;
    logic                     r_tick;
    logic                     r_clk_div;

    logic [DUTY_W-1:0]        r_cnt;
    logic [DUTY_W-1:0]        r_active_period;
    logic [DUTY_W-1:0]        r_shadow_period;
    logic [NUM_CH*DUTY_W-1:0] r_active_duty;
    logic [NUM_CH*DUTY_W-1:0] r_shadow_duty;
    logic                     r_pending;
    logic                     r_update_done;
    logic                     r_frame_clk;
    logic [NUM_CH-1:0]        r_pwm;
    logic [NUM_CH-1:0]        w_pwm_next;

    logic                     w_period_end;
    logic                     w_apply;

    // ------------------------------------------------------------------
    // Prescaler. tick/clk_div are registered from the next count so they
    // line up with pre_cnt yet still read 0 in the cycle after reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_pre_next = (r_pre_cnt == c_pre_max) ? '0 : r_pre_cnt + PRE_W'(1);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_clk_div <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_next;
            r_tick    <= (w_pre_next == c_pre_max);
            r_clk_div <= (w_pre_next < c_pre_half);
        end
    end

    // ------------------------------------------------------------------
    // Period counter, shadow handshake and frame clock
    // ------------------------------------------------------------------
    assign w_period_end = r_tick && (r_cnt == r_active_period);
    assign w_apply      = w_period_end && r_pending;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_cnt           <= '0;
            r_active_period <= c_reset_period;
            r_active_duty   <= '0;
            r_shadow_period <= '0;
            r_shadow_duty   <= '0;
            r_pending       <= 1'b0;
            r_update_done   <= 1'b0;
            r_frame_clk     <= 1'b0;
        end else begin
            if (r_tick) begin
                r_cnt <= (r_cnt == r_active_period) ? '0 : r_cnt + DUTY_W'(1);
            end

            // Apply reads the old shadow, so a coincident load lands one
            // boundary later with pending kept high.
            if (w_apply) begin
                r_active_period <= r_shadow_period;
                r_active_duty   <= r_shadow_duty;
            end

            if (load) begin
                r_shadow_period <= period;
                r_shadow_duty   <= duty;
                r_pending       <= 1'b1;
            end else if (w_apply) begin
                r_pending       <= 1'b0;
            end

            r_update_done <= w_apply;

            if (w_period_end) begin
                r_frame_clk <= ~r_frame_clk;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel compare; duty above period gives a constant-high output
    // because cnt never exceeds the active period.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DUTY_W-1:0] w_duty_ch;
        assign w_duty_ch      = r_active_duty[gi*DUTY_W +: DUTY_W];
        assign w_pwm_next[gi] = ch_enable[gi] && (r_cnt < w_duty_ch);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    assign pending     = r_pending;
    assign update_done = r_update_done;
    assign tick        = r_tick;
    assign clk_div     = r_clk_div;
    assign period_end  = w_period_end;
    assign frame_clk   = r_frame_clk;
    assign pwm_out     = r_pwm;

endmodule
`default_nettype wire
